team_06_i2s_tx_multi: RTL and testbench

TEAM_06_I2S_TX_MULTI -- requirements
Module: team_06_i2s_tx_multi

---
 rtl/team_06_i2s_tx_multi.sv | 129 ++++++++++++
 tb/tb_team_06_i2s_tx_multi.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/team_06_i2s_tx_multi.sv
// I2S transmitter with sample FIFO, mono/stereo slot mapping and bclk divider.
// Define TEAM06_I2S_UNDERFLOW_CNT_EN to add the saturating underflow_count output.
module team_06_i2s_tx_multi #(
  parameter int DATA_W     = 8,
  parameter int CHANNELS   = 1,
  parameter int CLK_DIV    = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          enable,
  output logic                          bclk,
  output logic                          ws,
  output logic                          sdata,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef TEAM06_I2S_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]                   underflow_count
`endif
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0]       BIT_LAST = 5'(DATA_W - 1);
  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [7:0]        div_cnt;
  logic [4:0]        bit_cnt;
  logic [DATA_W-1:0] sreg, hold, head, load_val;
  logic              full, empty, push, pop, pop_req, fall, slot_start;

  assign fifo_level   = wr_ptr - rd_ptr;
  assign full         = (fifo_level == FULL_LVL);
  assign empty        = (wr_ptr == rd_ptr);
  assign sample_ready = !full;
  assign push         = sample_valid && sample_ready;
  assign head         = mem[rd_ptr[PTR_W-1:0]];

  // A fall event is the clk cycle whose edge drives bclk 1->0.
  assign fall       = enable && bclk && (div_cnt == DIV_LAST);
  assign slot_start = fall && (bit_cnt == '0);
  // Mono pops only for the left slot; the right slot replays the held sample.
  assign pop_req    = slot_start && ((CHANNELS == 2) || !ws);
  assign pop        = pop_req && !empty;

  always_comb begin
    load_val = hold;
    if (pop_req) load_val = empty ? '0 : head;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= sample_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      ws        <= 1'b0;
      sdata     <= 1'b0;
      sreg      <= '0;
      hold      <= '0;
      underflow <= 1'b0;
    end else if (!enable) begin
      bit_cnt   <= '0;
      ws        <= 1'b0;
      sdata     <= 1'b0;
      sreg      <= '0;
      hold      <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= pop_req && empty;
      if (fall) begin
        if (slot_start) begin
          sreg  <= load_val;
          sdata <= load_val[DATA_W-1];
          if (pop_req) hold <= load_val;
        end else begin
          sreg  <= sreg << 1;
          sdata <= sreg[DATA_W-2];
        end
        if (bit_cnt == BIT_LAST) begin
          bit_cnt <= '0;
          ws      <= ~ws;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

`ifdef TEAM06_I2S_UNDERFLOW_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) underflow_count <= '0;
    else if (underflow && (underflow_count != '1)) underflow_count <= underflow_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_team_06_i2s_tx_multi.sv
// Directed bench: a stereo and a mono instance share stimulus; each task checks one scenario.
module tb_team_06_i2s_tx_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       enable = 1'b0;

  logic       s_ready, s_bclk, s_ws, s_sdata, s_underflow;
  logic [2:0] s_level;
  logic       m_ready, m_bclk, m_ws, m_sdata, m_underflow;
  logic [2:0] m_level;
`ifdef TEAM06_I2S_UNDERFLOW_CNT_EN
  logic [15:0] s_ucnt, m_ucnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  team_06_i2s_tx_multi #(.DATA_W(8), .CHANNELS(2), .CLK_DIV(2), .FIFO_DEPTH(4)) dut_stereo (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(s_ready), .enable(enable), .bclk(s_bclk), .ws(s_ws), .sdata(s_sdata),
    .underflow(s_underflow), .fifo_level(s_level)
`ifdef TEAM06_I2S_UNDERFLOW_CNT_EN
    , .underflow_count(s_ucnt)
`endif
  );

  team_06_i2s_tx_multi #(.DATA_W(8), .CHANNELS(1), .CLK_DIV(2), .FIFO_DEPTH(4)) dut_mono (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(m_ready), .enable(enable), .bclk(m_bclk), .ws(m_ws), .sdata(m_sdata),
    .underflow(m_underflow), .fifo_level(m_level)
`ifdef TEAM06_I2S_UNDERFLOW_CNT_EN
    , .underflow_count(m_ucnt)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    enable = 1'b0;
    sample_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_one(input logic [7:0] v);
    sample_valid = 1'b1;
    sample_in = v;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests++; if ({s_bclk, s_ws, s_sdata, s_underflow} !== 4'b0000) begin
      fails++; $display("FAIL reset_outs: got %b expected 0000", {s_bclk, s_ws, s_sdata, s_underflow}); end
    tests++; if (s_level !== 3'd0 || m_level !== 3'd0) begin
      fails++; $display("FAIL reset_level: got %0d/%0d expected 0/0", s_level, m_level); end
    tests++; if (s_ready !== 1'b1 || m_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b/%b expected 1/1", s_ready, m_ready); end
    tests++; if ({m_bclk, m_ws, m_sdata, m_underflow} !== 4'b0000) begin
      fails++; $display("FAIL reset_mono_outs: got %b expected 0000", {m_bclk, m_ws, m_sdata, m_underflow}); end
  endtask

  task automatic test_stereo;
    logic [15:0] frame;
    logic exp_b, exp_d, exp_w;
    logic [2:0] exp_l;
    int k;
    frame = 16'hA53C;
    do_reset();
    push_one(8'hA5);
    push_one(8'h3C);
    tests++; if (s_level !== 3'd2) begin fails++; $display("FAIL stereo_prelevel: got %0d expected 2", s_level); end
    enable = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      step();
      exp_b = ((c / 2) % 2) == 1;
      tests++; if (s_bclk !== exp_b) begin fails++; $display("FAIL stereo_bclk c=%0d: got %b expected %b", c, s_bclk, exp_b); end
      if (c % 4 == 0) begin
        k = c / 4 - 1;
        exp_d = frame[15 - k];
        exp_w = (k >= 7 && k < 15);
        exp_l = (k < 8) ? 3'd1 : 3'd0;
        tests++; if (s_sdata !== exp_d) begin fails++; $display("FAIL stereo_sdata k=%0d: got %b expected %b", k, s_sdata, exp_d); end
        tests++; if (s_ws !== exp_w) begin fails++; $display("FAIL stereo_ws k=%0d: got %b expected %b", k, s_ws, exp_w); end
        tests++; if (s_level !== exp_l) begin fails++; $display("FAIL stereo_level k=%0d: got %0d expected %0d", k, s_level, exp_l); end
      end
    end
    enable = 1'b0;
    step();
    tests++; if ({s_bclk, s_ws, s_sdata} !== 3'b000) begin
      fails++; $display("FAIL stereo_disable: got %b expected 000", {s_bclk, s_ws, s_sdata}); end
  endtask

  task automatic test_mono;
    logic [7:0] a, b;
    logic exp_d;
    logic [2:0] exp_l;
    int k;
    a = 8'h81;
    b = 8'h42;
    do_reset();
    push_one(a);
    tests++; if (m_level !== 3'd1) begin fails++; $display("FAIL mono_prelevel: got %0d expected 1", m_level); end
    enable = 1'b1;
    for (int c = 1; c <= 68; c++) begin
      step();
      sample_valid = 1'b0;
      if (c == 9) begin sample_valid = 1'b1; sample_in = b; end
      if (c % 4 == 0) begin
        k = c / 4 - 1;
        exp_d = (k < 16) ? a[7 - (k % 8)] : b[7 - (k - 16)];
        exp_l = (k >= 2 && k < 16) ? 3'd1 : 3'd0;
        tests++; if (m_sdata !== exp_d) begin fails++; $display("FAIL mono_sdata k=%0d: got %b expected %b", k, m_sdata, exp_d); end
        tests++; if (m_level !== exp_l) begin fails++; $display("FAIL mono_level k=%0d: got %0d expected %0d", k, m_level, exp_l); end
        tests++; if (m_underflow !== 1'b0) begin fails++; $display("FAIL mono_underflow k=%0d: got %b expected 0", k, m_underflow); end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_full_wrap;
    logic [7:0] first6 [6];
    logic [7:0] next8 [8];
    logic [7:0] stream [12];
    logic [7:0] cur;
    logic exp_d;
    int k, j;
    first6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    next8  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    for (int i = 0; i < 4; i++) stream[i] = first6[i];
    for (int i = 0; i < 8; i++) stream[i + 4] = next8[i];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sample_valid = 1'b1;
      sample_in = first6[i];
      tests++; if (s_ready !== (i < 4)) begin fails++; $display("FAIL full_ready i=%0d: got %b expected %b", i, s_ready, (i < 4)); end
      tests++; if (s_level !== 3'((i < 4) ? i : 4)) begin fails++; $display("FAIL full_level i=%0d: got %0d", i, s_level); end
      step();
    end
    sample_valid = 1'b0;
    tests++; if (s_level !== 3'd4 || s_ready !== 1'b0) begin
      fails++; $display("FAIL full_final: got level %0d ready %b expected 4 0", s_level, s_ready); end
    enable = 1'b1;
    for (int c = 1; c <= 384; c++) begin
      step();
      sample_valid = 1'b0;
      if (c % 4 == 0) begin
        k = c / 4 - 1;
        cur = stream[k / 8];
        exp_d = cur[7 - (k % 8)];
        tests++; if (s_sdata !== exp_d) begin fails++; $display("FAIL wrap_sdata k=%0d: got %b expected %b", k, s_sdata, exp_d); end
      end
      if (c % 32 == 5 && c / 32 < 8) begin
        j = c / 32;
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL wrap_ready j=%0d: got %b expected 1", j, s_ready); end
        sample_valid = 1'b1;
        sample_in = next8[j];
      end
    end
    tests++; if (s_level !== 3'd0) begin fails++; $display("FAIL wrap_drain: got %0d expected 0", s_level); end
    enable = 1'b0;
  endtask

  task automatic test_simultaneous;
    do_reset();
    push_one(8'hC5);
    push_one(8'h5A);
    enable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      sample_valid = 1'b0;
      if (c == 3) begin
        tests++; if (s_level !== 3'd2) begin fails++; $display("FAIL simul_before: got %0d expected 2", s_level); end
        sample_valid = 1'b1;
        sample_in = 8'h77;
      end
      if (c == 4) begin
        tests++; if (s_level !== 3'd2) begin fails++; $display("FAIL simul_level: got %0d expected 2", s_level); end
        tests++; if (s_sdata !== 1'b1) begin fails++; $display("FAIL simul_sdata: got %b expected 1", s_sdata); end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_underflow;
    logic exp_u;
    do_reset();
    enable = 1'b1;
    for (int c = 1; c <= 65; c++) begin
      step();
      exp_u = (c == 4 || c == 36);
      tests++; if (s_underflow !== exp_u) begin fails++; $display("FAIL uflow_pulse c=%0d: got %b expected %b", c, s_underflow, exp_u); end
      tests++; if (s_sdata !== 1'b0 || s_level !== 3'd0) begin
        fails++; $display("FAIL uflow_data c=%0d: got sdata %b level %0d expected 0 0", c, s_sdata, s_level); end
`ifdef TEAM06_I2S_UNDERFLOW_CNT_EN
      if (c == 64) begin
        tests++; if (s_ucnt !== 16'd2) begin fails++; $display("FAIL uflow_count: got %0d expected 2", s_ucnt); end
      end
`endif
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid_slot;
    do_reset();
    push_one(8'hFF);
    push_one(8'h01);
    push_one(8'h02);
    push_one(8'h03);
    enable = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c == 4) begin
        tests++; if (s_level !== 3'd3) begin fails++; $display("FAIL rstmid_level: got %0d expected 3", s_level); end
      end
    end
    tests++; if (s_bclk !== 1'b1 || s_sdata !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre: got bclk %b sdata %b expected 1 1", s_bclk, s_sdata); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({s_bclk, s_ws, s_sdata, s_underflow} !== 4'b0000) begin
      fails++; $display("FAIL rstmid_outs: got %b expected 0000", {s_bclk, s_ws, s_sdata, s_underflow}); end
    tests++; if (s_level !== 3'd0 || s_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_fifo: got level %0d ready %b expected 0 1", s_level, s_ready); end
    #1 rst = 1'b0;
    sample_valid = 1'b1;
    sample_in = 8'hC3;
    for (int c = 1; c <= 4; c++) begin
      step();
      sample_valid = 1'b0;
      if (c == 1) begin
        tests++; if (s_level !== 3'd1) begin fails++; $display("FAIL resume_push: got %0d expected 1", s_level); end
      end
    end
    tests++; if ({s_bclk, s_ws, s_sdata} !== 3'b001 || s_level !== 3'd0) begin
      fails++; $display("FAIL resume_first: got %b level %0d expected 001 level 0", {s_bclk, s_ws, s_sdata}, s_level); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stereo();
    test_mono();
    test_full_wrap();
    test_simultaneous();
    test_underflow();
    test_reset_mid_slot();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
